// File: rtl/vc_to_d_arbiter_pkg.sv
// Shared definitions for the VC-to-destination transmit path.
// Holds the FSM state encoding and default geometry used by the arbiter
// and by the top-level transmit FSM.
package vc_to_d_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StHold = 2'd2
  } arb_state_e;

  localparam int unsigned DataWidthDef = 6;
  localparam int unsigned DestBitDef   = 4;
  localparam int unsigned MaxBurstDef  = 4;
  localparam int unsigned CntWDef      = 3;

endpackage

// File: rtl/vc_to_d_arbiter_if.sv
// Handshake bundle between the VC0/VC1 source FIFOs, the arbiter and the
// D0/D1 destination FIFOs.
//   master : arbiter side (drives pops, writes, idle)
//   slave  : FIFO/environment side (drives empty flags, read data, almost-full)
interface vc_to_d_arbiter_if
  import vc_to_d_arbiter_pkg::*;
#(
  parameter int unsigned data_width = DataWidthDef
) ();

  logic                  vc0_empty;
  logic                  vc1_empty;
  logic [data_width-1:0] vc0_data_out;
  logic [data_width-1:0] vc1_data_out;
  logic                  almost_full_fifo_D0;
  logic                  almost_full_fifo_D1;
  logic                  vc0_rd_enable;
  logic                  vc1_rd_enable;
  logic                  d0_wr_enable;
  logic                  d1_wr_enable;
  logic [data_width-1:0] d0_data_in;
  logic [data_width-1:0] d1_data_in;
  logic                  idle;

  modport master (
    input  vc0_empty, vc1_empty, vc0_data_out, vc1_data_out,
    input  almost_full_fifo_D0, almost_full_fifo_D1,
    output vc0_rd_enable, vc1_rd_enable,
    output d0_wr_enable, d1_wr_enable, d0_data_in, d1_data_in, idle
  );

  modport slave (
    output vc0_empty, vc1_empty, vc0_data_out, vc1_data_out,
    output almost_full_fifo_D0, almost_full_fifo_D1,
    input  vc0_rd_enable, vc1_rd_enable,
    input  d0_wr_enable, d1_wr_enable, d0_data_in, d1_data_in, idle
  );

endinterface

// File: rtl/vc_to_d_arbiter_core.sv
// vc_arbiter_core: VC0-priority grant logic with an anti-starvation burst
// limit. VC0 may win at most MAX_BURST consecutive grants while VC1 waits.
// Ports:
//   clk, reset     clock, async active-high reset
//   init           sync enable; low clears the burst counter
//   pop_allowed    FSM in RUN, no backpressure, init high
//   vc0_empty      VC0 empty flag
//   vc1_empty      VC1 empty flag
//   grant0/grant1  combinational pop grants (mutually exclusive)
module vc_arbiter_core
  import vc_to_d_arbiter_pkg::*;
#(
  parameter int unsigned MAX_BURST = MaxBurstDef,
  parameter int unsigned CNT_W     = CntWDef
) (
  input  logic clk,
  input  logic reset,
  input  logic init,
  input  logic pop_allowed,
  input  logic vc0_empty,
  input  logic vc1_empty,
  output logic grant0,
  output logic grant1
);

  localparam logic [CNT_W-1:0] BurstMax = CNT_W'(MAX_BURST);

  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;

  always_comb begin
    grant0 = pop_allowed && !vc0_empty && (vc1_empty || (burst_cnt_q < BurstMax));
    grant1 = pop_allowed && !vc1_empty && !grant0;
  end

  always_comb begin
    burst_cnt_d = burst_cnt_q;
    if (!init) begin
      burst_cnt_d = '0;
    end else if (grant1 || vc1_empty) begin
      // Counting only matters while VC1 is actually waiting.
      burst_cnt_d = '0;
    end else if (grant0 && (burst_cnt_q != BurstMax)) begin
      burst_cnt_d = burst_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      burst_cnt_q <= '0;
    end else begin
      burst_cnt_q <= burst_cnt_d;
    end
  end

endmodule

// File: rtl/vc_to_d_arbiter.sv
// vc_to_d_arbiter: drains VC0/VC1 and steers each word to D0 or D1 by
// word[DEST_BIT]. Pops are combinational; the selected word is captured one
// cycle later and written with a registered strobe two cycles after the pop.
// Ports:
//   clk    system clock
//   reset  async active-high reset
//   init   sync enable; low returns everything to idle values
//   bus    master view of the FIFO handshake bundle
module vc_to_d_arbiter
  import vc_to_d_arbiter_pkg::*;
#(
  parameter int unsigned data_width = DataWidthDef,
  parameter int unsigned DEST_BIT   = DestBitDef,
  parameter int unsigned MAX_BURST  = MaxBurstDef,
  parameter int unsigned CNT_W      = CntWDef
) (
  input logic               clk,
  input logic               reset,
  input logic               init,
  vc_to_d_arbiter_if.master bus
);

  arb_state_e            state_q;
  logic                  inflight_valid_q;
  logic                  inflight_src_q;   // 0 = VC0, 1 = VC1
  logic                  d0_wr_q, d1_wr_q;
  logic [data_width-1:0] d0_data_q, d1_data_q;
  logic                  idle_q;

  logic                  af_any;
  logic                  pop_allowed;
  logic                  grant0, grant1;
  logic [data_width-1:0] word;
  logic                  to_d1;

  always_comb begin
    af_any      = bus.almost_full_fifo_D0 || bus.almost_full_fifo_D1;
    pop_allowed = !reset && init && (state_q == StRun) && !af_any;
    word        = inflight_src_q ? bus.vc1_data_out : bus.vc0_data_out;
    to_d1       = word[DEST_BIT];
  end

  vc_arbiter_core #(
    .MAX_BURST (MAX_BURST),
    .CNT_W     (CNT_W)
  ) u_core (
    .clk         (clk),
    .reset       (reset),
    .init        (init),
    .pop_allowed (pop_allowed),
    .vc0_empty   (bus.vc0_empty),
    .vc1_empty   (bus.vc1_empty),
    .grant0      (grant0),
    .grant1      (grant1)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= StIdle;
      inflight_valid_q <= 1'b0;
      inflight_src_q   <= 1'b0;
      d0_wr_q          <= 1'b0;
      d1_wr_q          <= 1'b0;
      d0_data_q        <= '0;
      d1_data_q        <= '0;
      idle_q           <= 1'b1;
    end else if (!init) begin
      // In-flight word is dropped; upstream FIFOs are flushed by the same init.
      state_q          <= StIdle;
      inflight_valid_q <= 1'b0;
      inflight_src_q   <= 1'b0;
      d0_wr_q          <= 1'b0;
      d1_wr_q          <= 1'b0;
      d0_data_q        <= '0;
      d1_data_q        <= '0;
      idle_q           <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle:  state_q <= StRun;
        StRun:   if (af_any) state_q <= StHold;
        StHold:  if (!af_any) state_q <= StRun;
        default: state_q <= StIdle;
      endcase
      inflight_valid_q <= grant0 || grant1;
      inflight_src_q   <= grant1;
      // A popped word is always written, regardless of almost-full.
      d0_wr_q          <= inflight_valid_q && !to_d1;
      d1_wr_q          <= inflight_valid_q && to_d1;
      d0_data_q        <= (inflight_valid_q && !to_d1) ? word : '0;
      d1_data_q        <= (inflight_valid_q && to_d1) ? word : '0;
      // With init high the FSM never stays in IDLE, so idle drops next cycle.
      idle_q           <= 1'b0;
    end
  end

  assign bus.vc0_rd_enable = grant0;
  assign bus.vc1_rd_enable = grant1;
  assign bus.d0_wr_enable  = d0_wr_q;
  assign bus.d1_wr_enable  = d1_wr_q;
  assign bus.d0_data_in    = d0_data_q;
  assign bus.d1_data_in    = d1_data_q;
  assign bus.idle          = idle_q;

endmodule

// File: tb/tb_vc_to_d_arbiter.sv
// Directed bench for vc_to_d_arbiter: simple VC FIFO models feed the DUT,
// every expected value is hand-computed from the intended behaviour.
module tb_vc_to_d_arbiter;

  localparam int unsigned DW = 6;

  logic clk = 1'b0;
  logic reset;
  logic init;
  logic af0, af1;

  always #5 clk = ~clk;

  vc_to_d_arbiter_if #(.data_width(DW)) bus ();

  vc_to_d_arbiter #(
    .data_width (DW),
    .DEST_BIT   (4),
    .MAX_BURST  (4),
    .CNT_W      (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .init  (init),
    .bus   (bus)
  );

  // Source FIFO models: write pointer advanced by stimulus, read pointer by pops.
  logic [DW-1:0] vc0_mem [0:63];
  logic [DW-1:0] vc1_mem [0:63];
  int            vc0_wp = 0, vc1_wp = 0;
  int            vc0_rp = 0, vc1_rp = 0;
  logic [DW-1:0] vc0_rd_data = '0, vc1_rd_data = '0;

  always @(posedge clk) begin
    if (reset || !init) begin
      vc0_rp <= vc0_wp;
      vc1_rp <= vc1_wp;
    end else begin
      if (bus.vc0_rd_enable) begin
        vc0_rd_data <= vc0_mem[vc0_rp];
        vc0_rp      <= vc0_rp + 1;
      end
      if (bus.vc1_rd_enable) begin
        vc1_rd_data <= vc1_mem[vc1_rp];
        vc1_rp      <= vc1_rp + 1;
      end
    end
  end

  assign bus.vc0_empty           = (vc0_wp == vc0_rp);
  assign bus.vc1_empty           = (vc1_wp == vc1_rp);
  assign bus.vc0_data_out        = vc0_rd_data;
  assign bus.vc1_data_out        = vc1_rd_data;
  assign bus.almost_full_fifo_D0 = af0;
  assign bus.almost_full_fifo_D1 = af1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push0(input logic [DW-1:0] w);
    vc0_mem[vc0_wp] = w;
    vc0_wp = vc0_wp + 1;
  endtask

  task automatic push1(input logic [DW-1:0] w);
    vc1_mem[vc1_wp] = w;
    vc1_wp = vc1_wp + 1;
  endtask

  task automatic check_rd(input string tag, input logic e0, input logic e1);
    check_eq({tag, ".rd0"}, 32'(bus.vc0_rd_enable), 32'(e0));
    check_eq({tag, ".rd1"}, 32'(bus.vc1_rd_enable), 32'(e1));
  endtask

  task automatic check_wr(input string tag, input logic w0, input logic [DW-1:0] d0,
                          input logic w1, input logic [DW-1:0] d1);
    check_eq({tag, ".d0_wr"}, 32'(bus.d0_wr_enable), 32'(w0));
    check_eq({tag, ".d0_data"}, 32'(bus.d0_data_in), 32'(d0));
    check_eq({tag, ".d1_wr"}, 32'(bus.d1_wr_enable), 32'(w1));
    check_eq({tag, ".d1_data"}, 32'(bus.d1_data_in), 32'(d1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] pat;
    logic [5:0]  pat2;
    int          i0, i1;

    reset = 1'b1;
    init  = 1'b0;
    af0   = 1'b0;
    af1   = 1'b0;
    repeat (2) tick();
    check_wr("reset", 1'b0, '0, 1'b0, '0);
    check_eq("reset.idle", 32'(bus.idle), 32'd1);
    check_rd("reset", 1'b0, 1'b0);
    reset = 1'b0;
    tick();
    check_eq("init_low.idle", 32'(bus.idle), 32'd1);

    // Single VC0 word to D0.
    push0(6'h05);
    init = 1'b1;
    #1;
    check_rd("t1.idle_state", 1'b0, 1'b0);
    tick();
    check_rd("t1.pop", 1'b1, 1'b0);
    tick();
    check_rd("t1.n1", 1'b0, 1'b0);
    check_wr("t1.n1", 1'b0, '0, 1'b0, '0);
    tick();
    check_wr("t1.n2", 1'b1, 6'h05, 1'b0, '0);
    check_eq("t1.n2.idle", 32'(bus.idle), 32'd0);
    tick();
    check_wr("t1.n3", 1'b0, '0, 1'b0, '0);

    // Back-to-back words to D1 then D0.
    push0(6'h12);
    push0(6'h03);
    #1;
    check_rd("t2.n0", 1'b1, 1'b0);
    tick();
    check_rd("t2.n1", 1'b1, 1'b0);
    tick();
    check_rd("t2.n2", 1'b0, 1'b0);
    check_wr("t2.n2", 1'b0, '0, 1'b1, 6'h12);
    tick();
    check_wr("t2.n3", 1'b1, 6'h03, 1'b0, '0);
    tick();
    check_wr("t2.n4", 1'b0, '0, 1'b0, '0);

    // Burst limit: 8 words each, VC0 words go to D0, VC1 words to D1.
    for (int i = 0; i < 8; i++) begin
      push0(6'(i));
      push1(6'h10 + 6'(i));
    end
    #1;
    pat = 16'hFE10;  // bit c = 1 when pop c is granted to VC1
    i0  = 0;
    i1  = 0;
    for (int c = 0; c < 18; c++) begin
      if (c < 16) check_rd($sformatf("t3.pop%0d", c), !pat[c], pat[c]);
      if (c >= 2) begin
        if (pat[c-2]) begin
          check_wr($sformatf("t3.wr%0d", c - 2), 1'b0, '0, 1'b1, 6'h10 + 6'(i1));
          i1++;
        end else begin
          check_wr($sformatf("t3.wr%0d", c - 2), 1'b1, 6'(i0), 1'b0, '0);
          i0++;
        end
      end
      tick();
    end

    // Backpressure: almost-full rises after a pop.
    push0(6'h01);
    push0(6'h02);
    push0(6'h03);
    #1;
    check_rd("t4.pop", 1'b1, 1'b0);
    tick();
    af0 = 1'b1;
    #1;
    check_rd("t4.af_block", 1'b0, 1'b0);
    tick();
    check_wr("t4.inflight", 1'b1, 6'h01, 1'b0, '0);
    check_rd("t4.hold", 1'b0, 1'b0);
    tick();
    check_rd("t4.hold2", 1'b0, 1'b0);
    af0 = 1'b0;
    #1;
    check_rd("t4.hold_clear", 1'b0, 1'b0);
    tick();
    check_rd("t4.resume", 1'b1, 1'b0);
    tick();
    check_rd("t4.resume2", 1'b1, 1'b0);
    tick();
    check_wr("t4.w2", 1'b1, 6'h02, 1'b0, '0);
    tick();
    check_wr("t4.w3", 1'b1, 6'h03, 1'b0, '0);
    tick();

    // Async reset mid-burst with VC1 waiting.
    for (int i = 1; i <= 6; i++) push0(6'(i));
    push1(6'h11);
    push1(6'h12);
    #1;
    check_rd("t5.pop0", 1'b1, 1'b0);
    repeat (3) tick();
    check_wr("t5.pre", 1'b1, 6'h02, 1'b0, '0);
    #3;
    reset = 1'b1;
    #1;
    check_wr("t5.async", 1'b0, '0, 1'b0, '0);
    check_eq("t5.async.idle", 32'(bus.idle), 32'd1);
    check_rd("t5.async", 1'b0, 1'b0);
    init = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    for (int i = 1; i <= 5; i++) push0(6'(i));
    push1(6'h11);
    init = 1'b1;
    #1;
    check_rd("t5.idle_state", 1'b0, 1'b0);
    tick();
    pat2 = 6'b010000;  // fresh burst counter: four VC0 grants before VC1
    for (int c = 0; c < 6; c++) begin
      check_rd($sformatf("t5.pop%0d", c), !pat2[c], pat2[c]);
      tick();
    end
    repeat (3) tick();

    // init low for one cycle drops the in-flight word.
    push0(6'h01);
    push0(6'h12);
    push0(6'h03);
    push0(6'h14);
    #1;
    check_rd("t6.pop", 1'b1, 1'b0);
    tick();
    init = 1'b0;
    #1;
    check_rd("t6.init_low", 1'b0, 1'b0);
    tick();
    check_wr("t6.dropped", 1'b0, '0, 1'b0, '0);
    check_eq("t6.idle", 32'(bus.idle), 32'd1);
    init = 1'b1;
    push0(6'h07);
    #1;
    check_rd("t6.idle_state", 1'b0, 1'b0);
    tick();
    check_rd("t6.first_pop", 1'b1, 1'b0);
    tick();
    check_rd("t6.n1", 1'b0, 1'b0);
    tick();
    check_wr("t6.write", 1'b1, 6'h07, 1'b0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
